// File: rtl/ascii_cmd_pkg.sv
// Shared types and constants for the ASCII command engine: FSM states,
// command codes, command text and response-buffer sizing.
package ascii_cmd_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    PARSE,
    SEND
  } state_t;

  typedef enum logic [1:0] {
    RESP_PING,
    RESP_VOLT,
    RESP_ERR
  } resp_kind_t;

  localparam logic [7:0] CMD_PING      = 8'd1;
  localparam logic [7:0] CMD_RESET     = 8'd2;
  localparam logic [7:0] CMD_VOLT_BASE = 8'd2;
  localparam logic [7:0] CMD_ERROR     = 8'hFF;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  localparam logic [7:0] CMD_TEXT    [3] = '{"c", "m", "d"};
  localparam logic [7:0] RESET_TEXT  [5] = '{"r", "e", "s", "e", "t"};
  localparam logic [7:0] VOLT_PREFIX [9] = '{"v", "o", "l", "t", "a", "g", "e", "c", "h"};

  // Longest response is either the hex sample plus CR or "resp\r".
  function automatic int resp_len(input int data_w);
    return ((data_w / 4 + 1) > 5) ? (data_w / 4 + 1) : 5;
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic int digit_val(input logic [7:0] c);
    return int'(c) - 48;
  endfunction

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational conversion of one 4-bit nibble to its uppercase ASCII hex digit.
module hex_nibble_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h37 + {4'h0, nibble};
  end

endmodule

// File: rtl/ascii_command_engine.sv
// Line-oriented ASCII command decoder with a per-channel sample store and streamed
// responses. Define CMD_ERROR_RESP_EN to answer rejected lines with "?\r".
module ascii_command_engine
  import ascii_cmd_pkg::*;
#(
  parameter  int NUM_CH   = 8,
  parameter  int DATA_W   = 32,
  parameter  int LINE_MAX = 12,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [CH_W-1:0]   adc_channel,
  input  logic              adc_data_valid,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        command_valid,
  output logic              rs_232_reset,
  output logic              busy
);

  localparam int DIGITS   = DATA_W / 4;
  localparam int RESP_LEN = resp_len(DATA_W);
  localparam int IDX_W    = $clog2(RESP_LEN);
  localparam int LEN_W    = $clog2(LINE_MAX + 1);

`ifdef CMD_ERROR_RESP_EN
  localparam bit ERR_RESP_EN = 1'b1;
`else
  localparam bit ERR_RESP_EN = 1'b0;
`endif

  state_t            state;
  state_t            state_next;

  logic              rx_sync;
  logic              rx_prev;
  logic [7:0]        rx_hold;
  logic              rx_rise;

  logic [7:0]        line_buf [LINE_MAX];
  logic [LEN_W-1:0]  line_len;
  logic              overflow;

  logic [DATA_W-1:0] values [NUM_CH];

  resp_kind_t        send_kind;
  logic [DATA_W-1:0] snapshot;
  logic [IDX_W-1:0]  send_idx;
  logic [IDX_W-1:0]  last_idx;
  logic              tx_fire;
  logic              send_done;

  logic              is_cmd;
  logic              is_reset;
  logic              prefix_ok;
  logic              is_volt;
  int                volt_n;
  logic [DATA_W-1:0] volt_value;

  logic [7:0]        parse_code;
  resp_kind_t        parse_kind;
  logic              parse_has_resp;
  logic              parse_rst;
  logic [IDX_W-1:0]  parse_last;

  logic [3:0]        nibble;
  logic [7:0]        hex_char;
  logic [7:0]        tx_char;

  assign rx_rise   = rx_sync & ~rx_prev;
  assign tx_fire   = tx_valid & tx_ready;
  assign send_done = tx_fire && (send_idx == last_idx);
  assign tx_byte   = tx_valid ? tx_char : 8'h00;

  // Match the assembled line against the fixed command words and the voltage form.
  always_comb begin
    is_cmd = (int'(line_len) == 3);
    for (int i = 0; i < 3; i++)
      if (line_buf[i] != CMD_TEXT[i]) is_cmd = 1'b0;

    is_reset = (int'(line_len) == 5);
    for (int i = 0; i < 5; i++)
      if (line_buf[i] != RESET_TEXT[i]) is_reset = 1'b0;

    prefix_ok = 1'b1;
    for (int i = 0; i < 9; i++)
      if (line_buf[i] != VOLT_PREFIX[i]) prefix_ok = 1'b0;

    volt_n = 0;
    if (prefix_ok && is_digit(line_buf[9]) && (line_buf[9] != "0")) begin
      if (int'(line_len) == 10)
        volt_n = digit_val(line_buf[9]);
      else if ((int'(line_len) == 11) && is_digit(line_buf[10]))
        volt_n = 10 * digit_val(line_buf[9]) + digit_val(line_buf[10]);
    end
    is_volt = (volt_n >= 1) && (volt_n <= NUM_CH);

    volt_value = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (volt_n == i + 1) volt_value = values[i];
  end

  // Command code and response selection; an overflowed line is always rejected.
  always_comb begin
    parse_code     = CMD_ERROR;
    parse_kind     = RESP_ERR;
    parse_has_resp = ERR_RESP_EN;
    parse_rst      = 1'b0;
    parse_last     = IDX_W'(1);
    if (!overflow) begin
      if (is_cmd) begin
        parse_code     = CMD_PING;
        parse_kind     = RESP_PING;
        parse_has_resp = 1'b1;
        parse_last     = IDX_W'(4);
      end else if (is_reset) begin
        parse_code     = CMD_RESET;
        parse_has_resp = 1'b0;
        parse_rst      = 1'b1;
      end else if (is_volt) begin
        parse_code     = CMD_VOLT_BASE + 8'(volt_n);
        parse_kind     = RESP_VOLT;
        parse_has_resp = 1'b1;
        parse_last     = IDX_W'(DIGITS);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (rx_rise && (rx_hold == ASCII_CR)) state_next = PARSE;
      PARSE:   state_next = parse_has_resp ? SEND : COLLECT;
      SEND:    if (send_done) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= COLLECT;
    else       state <= state_next;
  end

  // Response byte for the current SEND index; hex digits go out MSB first.
  always_comb begin
    int shift;
    shift = 4 * (DIGITS - 1 - int'(send_idx));
    if (shift < 0) shift = 0;
    nibble  = 4'(snapshot >> shift);
    tx_char = ASCII_CR;
    case (send_kind)
      RESP_PING: begin
        case (int'(send_idx))
          0:       tx_char = "r";
          1:       tx_char = "e";
          2:       tx_char = "s";
          3:       tx_char = "p";
          default: tx_char = ASCII_CR;
        endcase
      end
      RESP_VOLT: if (int'(send_idx) < DIGITS) tx_char = hex_char;
      RESP_ERR:  if (send_idx == '0) tx_char = ASCII_QMARK;
      default:   tx_char = ASCII_CR;
    endcase
  end

  hex_nibble_to_ascii u_hex (
    .nibble(nibble),
    .ascii (hex_char)
  );

  // rx_valid is sampled once so a byte lands one edge after its rising edge is seen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_sync  <= 1'b0;
      rx_prev  <= 1'b0;
      rx_hold  <= '0;
      line_len <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < LINE_MAX; i++) line_buf[i] <= '0;
    end else begin
      rx_sync <= rx_valid;
      rx_prev <= rx_sync;
      rx_hold <= rx_byte;
      if (state == PARSE) begin
        line_len <= '0;
        overflow <= 1'b0;
      end else if ((state == COLLECT) && rx_rise &&
                   (rx_hold != ASCII_CR) && (rx_hold != ASCII_LF)) begin
        if (int'(line_len) == LINE_MAX) begin
          overflow <= 1'b1;
        end else begin
          for (int i = 0; i < LINE_MAX; i++)
            if (int'(line_len) == i) line_buf[i] <= rx_hold;
          line_len <= line_len + LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) values[i] <= '0;
    end else if (adc_data_valid) begin
      for (int i = 0; i < NUM_CH; i++)
        if (adc_channel == CH_W'(i)) values[i] <= adc_data;
    end
  end

  // The sample is snapshotted in PARSE so later ADC writes cannot tear a response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      send_kind     <= RESP_ERR;
      snapshot      <= '0;
      send_idx      <= '0;
      last_idx      <= '0;
      tx_valid      <= 1'b0;
      command_valid <= '0;
      rs_232_reset  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      rs_232_reset <= 1'b0;
      tx_valid     <= (state_next == SEND);
      busy         <= (state_next != COLLECT);
      if (state == PARSE) begin
        command_valid <= parse_code;
        rs_232_reset  <= parse_rst;
        send_kind     <= parse_kind;
        snapshot      <= volt_value;
        send_idx      <= '0;
        last_idx      <= parse_last;
      end else if ((state == SEND) && tx_fire) begin
        send_idx <= send_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ascii_command_engine.sv
// Randomised self-checking bench for ascii_command_engine; expected responses come
// from a string-level model of the command language.
`timescale 1ns/1ps
module tb_ascii_command_engine;

  localparam int NUM_CH   = 8;
  localparam int DATA_W   = 32;
  localparam int LINE_MAX = 12;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [31:0] adc_data;
  logic [2:0]  adc_channel;
  logic        adc_data_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  command_valid;
  logic        rs_232_reset;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] model_vals [NUM_CH];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  ascii_command_engine #(
    .NUM_CH  (NUM_CH),
    .DATA_W  (DATA_W),
    .LINE_MAX(LINE_MAX)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .adc_data      (adc_data),
    .adc_channel   (adc_channel),
    .adc_data_valid(adc_data_valid),
    .tx_byte       (tx_byte),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .command_valid (command_valid),
    .rs_232_reset  (rs_232_reset),
    .busy          (busy)
  );

  function automatic string hex_text(input logic [31:0] v);
    string hexd = "0123456789ABCDEF";
    string r = "";
    for (int i = 7; i >= 0; i--) r = {r, hexd.substr(int'(v[4*i +: 4]), int'(v[4*i +: 4]))};
    return {r, "\015"};
  endfunction

  function automatic string show(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) r = $sformatf("%s%02h ", r, s[i]);
    return (s.len() == 0) ? "<none>" : r;
  endfunction

  // Reference: strip LF, reject overlong lines, then match whole-line commands.
  function automatic void model(input string raw, output string resp,
                                output logic [7:0] code, output bit rst);
    string s = "";
    string digits;
    int    n;
    bit    ok;
    for (int i = 0; i < raw.len(); i++)
      if (raw[i] != 8'h0A) s = {s, raw.substr(i, i)};
    code = 8'hFF;
    rst  = 1'b0;
`ifdef CMD_ERROR_RESP_EN
    resp = "?\015";
`else
    resp = "";
`endif
    if (s.len() > LINE_MAX) return;
    if (s == "cmd") begin
      resp = "resp\015";
      code = 8'd1;
    end else if (s == "reset") begin
      resp = "";
      code = 8'd2;
      rst  = 1'b1;
    end else if (s.len() >= 10 && s.len() <= 11 && s.substr(0, 8) == "voltagech") begin
      digits = s.substr(9, s.len() - 1);
      ok = (digits[0] != "0");
      for (int i = 0; i < digits.len(); i++)
        if (digits[i] < "0" || digits[i] > "9") ok = 1'b0;
      n = digits.atoi();
      if (ok && n >= 1 && n <= NUM_CH) begin
        code = 8'(2 + n);
        resp = hex_text(model_vals[n-1]);
      end
    end
  endfunction

  function automatic string rand_word(input int len);
    string letters = "abcdefghijklmnopqrstuvwxyz";
    string r = "";
    int    k;
    for (int i = 0; i < len; i++) begin
      k = $urandom_range(0, 25);
      r = {r, letters.substr(k, k)};
    end
    return r;
  endfunction

  task automatic send_char(input byte c, output int edge_cyc);
    @(posedge clock); #1;
    rx_byte  = c;
    rx_valid = 1'b1;
    edge_cyc = cyc + 1;
    @(posedge clock); #1;
    rx_valid = 1'b0;
    @(posedge clock);
  endtask

  task automatic adc_write(input int ch, input logic [31:0] v);
    @(posedge clock); #1;
    adc_channel    = 3'(ch);
    adc_data       = v;
    adc_data_valid = 1'b1;
    @(posedge clock); #1;
    adc_data_valid = 1'b0;
    model_vals[ch] = v;
  endtask

  // mode: 0 ready always, 1 ready alternating, 2 ready random; inject adds noise mid-SEND.
  task automatic run_line(input string line, input int mode, input bit inject, input string name);
    string      exp_resp;
    string      got = "";
    logic [7:0] exp_code;
    bit         exp_rst;
    int         cr_cyc, first_cyc = -1, rsn = 0;
    bit         done = 1'b0, seen = 1'b0, held = 1'b0;
    logic [7:0] held_b = 8'h00;
    model(line, exp_resp, exp_code, exp_rst);
    tx_ready = 1'b1;
    for (int i = 0; i < line.len(); i++) send_char(line[i], cr_cyc);
    send_char(8'h0D, cr_cyc);
    for (int k = 0; k < 400 && !done; k++) begin
      @(posedge clock); #1;
      if (held && tx_valid) begin
        checks++;
        if (tx_byte !== held_b) begin
          errors++;
          $display("[TB] FAIL %s stall_hold: tx_byte=%02h expected %02h", name, tx_byte, held_b);
        end
      end
      if (rs_232_reset) rsn++;
      if (tx_valid && !seen) begin
        seen      = 1'b1;
        first_cyc = cyc;
      end
      case (mode)
        1:       tx_ready = (k % 2 == 0);
        2:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b1;
      endcase
      if (tx_valid && tx_ready) got = $sformatf("%s%c", got, tx_byte);
      held   = tx_valid && !tx_ready;
      held_b = tx_byte;
      if (inject) begin
        if (k == 2) begin rx_byte = "Z"; rx_valid = 1'b1; end
        if (k == 3) rx_valid = 1'b0;
        if (k == 4) begin
          adc_channel    = 3'($urandom_range(0, NUM_CH - 1));
          adc_data       = $urandom;
          adc_data_valid = 1'b1;
          model_vals[adc_channel] = adc_data;
        end
        if (k == 5) adc_data_valid = 1'b0;
      end
      if (k >= 3 && !busy) done = 1'b1;
    end
    tx_ready = 1'b1;
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s timeout: busy=%0b expected 0 within 400 cycles", name, busy);
    end
    checks++;
    if (got != exp_resp) begin
      errors++;
      $display("[TB] FAIL %s response: got %s expected %s", name, show(got), show(exp_resp));
    end
    checks++;
    if (command_valid !== exp_code) begin
      errors++;
      $display("[TB] FAIL %s command_valid: got %02h expected %02h", name, command_valid, exp_code);
    end
    checks++;
    if (rsn != int'(exp_rst)) begin
      errors++;
      $display("[TB] FAIL %s rs_232_reset cycles: got %0d expected %0d", name, rsn, exp_rst);
    end
    if (exp_resp.len() > 0) begin
      checks++;
      if (first_cyc - cr_cyc != 2) begin
        errors++;
        $display("[TB] FAIL %s latency: first byte %0d cycles after CR expected 2", name, first_cyc - cr_cyc);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks += 5;
    if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset tx_valid: got %b expected 0", tx_valid); end
    if (tx_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset tx_byte: got %02h expected 00", tx_byte); end
    if (command_valid !== 8'h00) begin errors++; $display("[TB] FAIL reset command_valid: got %02h expected 00", command_valid); end
    if (rs_232_reset !== 1'b0) begin errors++; $display("[TB] FAIL reset rs_232_reset: got %b expected 0", rs_232_reset); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
    reset = 1'b0;
    for (int i = 0; i < NUM_CH; i++) model_vals[i] = '0;
  endtask

  task automatic test_cmd();
    run_line("cmd", 0, 1'b0, "cmd");
    run_line("c\nmd", 2, 1'b0, "cmd_with_lf");
  endtask

  task automatic test_voltage();
    int ch;
    adc_write(2, 32'h00AB_CDEF);
    run_line("voltagech3", 0, 1'b0, "volt3");
    run_line("voltagech3", 1, 1'b0, "volt3_stall");
    run_line("voltagech1", 0, 1'b0, "volt1_zero");
    for (int it = 0; it < 6; it++) begin
      ch = $urandom_range(0, NUM_CH - 1);
      adc_write(ch, $urandom);
      adc_write($urandom_range(0, NUM_CH - 1), $urandom);
      run_line($sformatf("voltagech%0d", ch + 1), it % 3, (it % 2) == 1, "volt_rand");
    end
    run_line("voltagech8", 2, 1'b0, "volt_top");
  endtask

  task automatic test_errors();
    run_line("voltagech9", 0, 1'b0, "volt9");
    run_line("voltagech03", 0, 1'b0, "volt03");
    run_line("voltagech0", 0, 1'b0, "volt0");
    run_line("voltagech10", 0, 1'b0, "volt10");
    run_line("", 0, 1'b0, "empty");
    run_line("Cmd", 0, 1'b0, "case");
    run_line("cmdx", 0, 1'b0, "cmd_long");
    for (int it = 0; it < 5; it++)
      run_line(rand_word($urandom_range(1, 15)), 2, 1'b0, "garbage");
  endtask

  task automatic test_overflow();
    run_line(rand_word(20), 0, 1'b0, "overflow20");
    run_line("cmd", 0, 1'b0, "cmd_after_overflow");
    run_line("voltagech1abc", 0, 1'b0, "overflow13");
  endtask

  task automatic test_uart_reset();
    run_line("reset", 0, 1'b0, "reset_cmd");
  endtask

  task automatic test_async_reset();
    int cr;
    string line = "voltagech3";
    adc_write(2, $urandom | 32'h1);
    tx_ready = 1'b0;
    for (int i = 0; i < line.len(); i++) send_char(line[i], cr);
    send_char(8'h0D, cr);
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (tx_valid !== 1'b1) begin errors++; $display("[TB] FAIL async_pre tx_valid: got %b expected 1", tx_valid); end
    #2 reset = 1'b1;
    #1;
    checks += 3;
    if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL async tx_valid: got %b expected 0", tx_valid); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async busy: got %b expected 0", busy); end
    if (command_valid !== 8'h00) begin errors++; $display("[TB] FAIL async command_valid: got %02h expected 00", command_valid); end
    @(posedge clock); #1;
    reset    = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) model_vals[i] = '0;
    run_line("voltagech3", 0, 1'b0, "volt_after_reset");
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 4; it++) run_line("cmd", it % 3, 1'b0, "b2b_cmd");
    run_line("voltagech5", 2, 1'b0, "b2b_volt");
  endtask

  initial begin
    reset          = 1'b1;
    rx_byte        = 8'h00;
    rx_valid       = 1'b0;
    adc_data       = '0;
    adc_channel    = '0;
    adc_data_valid = 1'b0;
    tx_ready       = 1'b1;
    test_reset();
    test_cmd();
    test_voltage();
    test_errors();
    test_overflow();
    test_uart_reset();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascii_command_engine.md
# ascii_command_engine

Parametrised successor to the RS-232 ASCII command decoder. It assembles received bytes into a bounded line buffer and decodes `cmd`, `reset` and `voltagechN` (N = 1..NUM_CH, decimal) on carriage return. Responses stream out byte-by-byte over a valid/ready handshake. It sits between the UART receiver/transmitter and the ADC sequencer, keeping one latched sample per channel.

## Interface
- `NUM_CH`, default 8: number of ADC channels, legal range 1..16.
- `DATA_W`, default 32: sample width, multiple of 4; the response carries DATA_W/4 hex digits.
- `LINE_MAX`, default 12: line buffer depth in characters, excluding CR; must be ≥ 11.
- `clock`, in, 1: system clock; single clock domain.
- `reset`, in, 1: asynchronous, active-high reset.
- `rx_byte`, in, 8: received character.
- `rx_valid`, in, 1: level from the UART; a byte is taken on its rising edge.
- `adc_data`, in, DATA_W: sample value.
- `adc_channel`, in, $clog2(NUM_CH) (min 1): zero-based channel of `adc_data`.
- `adc_data_valid`, in, 1: one-cycle strobe that writes the sample.
- `tx_byte`, out, 8: response character.
- `tx_valid`, out, 1: `tx_byte` is valid; held until accepted.
- `tx_ready`, in, 1: transmitter accepts the byte.
- `command_valid`, out, 8: code of the last decoded command.
- `rs_232_reset`, out, 1: one-cycle pulse requesting a UART reset.
- `busy`, out, 1: high in PARSE and SEND.

## Operation
- Reset values: all outputs 0; line buffer empty; overflow flag 0; all channel registers 0; state COLLECT.
- Channel store: on `adc_data_valid`, `value[adc_channel] <= adc_data`. If `adc_channel` ≥ NUM_CH, the write is ignored. Writes are accepted in every state.
- COLLECT: on a `rx_valid` rising edge:
  - CR (0x0D) → PARSE.
  - LF (0x0A) → ignored.
  - Any other byte is appended. If the buffer is already full, the overflow flag is set and the byte is dropped.
- PARSE lasts one cycle and compares the whole line (exact length, case-sensitive):
  - `cmd` → response `resp\r`; `command_valid` = 1.
  - `reset` → `rs_232_reset` pulses for 1 cycle; no response; `command_valid` = 2.
  - `voltagechN`, where N is 1–2 decimal digits with no leading zero and 1 ≤ N ≤ NUM_CH → response is `value[N-1]` as DATA_W/4 uppercase hex digits, MSB first, followed by `\r`; `command_valid` = 2+N. The value is snapshotted in PARSE, so later channel writes cannot tear the response.
  - Anything else, an empty line, or overflow flag set → `command_valid` = 8'hFF; response as described under Configuration.
  - Leaving PARSE clears the buffer and the overflow flag.
- SEND: indexes the response bytes. A byte transfers on a cycle where `tx_valid` and `tx_ready` are both high. After the final `\r` transfers, `tx_valid` drops and the state returns to COLLECT.
- Bytes whose `rx_valid` rising edge falls in PARSE or SEND are discarded.
- `command_valid` holds its value until the next PARSE.

## Timing
- `rx_valid` rising edge sampled at edge t → byte stored at edge t+1.
- CR sampled at edge t → PARSE during cycle t+1 → `tx_valid` high and first byte on `tx_byte` from edge t+2. `command_valid` and `rs_232_reset` also update at edge t+2.
- With `tx_ready` held high, one byte transfers per cycle: a voltage response (DATA_W=32) takes 9 cycles, `resp\r` takes 5.
- `tx_byte` is stable while `tx_valid` is high and `tx_ready` is low.
- `busy` is registered: high from edge t+1 until the edge after the last transfer.
- An asynchronous `reset` during SEND forces `tx_valid` low immediately. The partial response is not resumed.

## Configuration
- `CMD_ERROR_RESP_EN`
  - Defined: a rejected line (unknown, empty or overflowed) produces the response `?\r`.
  - Undefined: a rejected line produces no response and returns directly to COLLECT; `command_valid` is still set to 8'hFF.

## Structure
- Package `ascii_cmd_pkg` holds:
  - State enum: COLLECT, PARSE, SEND.
  - Command code constants: CMD_PING=1, CMD_RESET=2, CMD_VOLT_BASE=2, CMD_ERROR=8'hFF.
  - ASCII constants for CR, LF and `?`.
  - Response buffer length: max(DATA_W/4+1, 5).
- Sub-module `hex_nibble_to_ascii`: combinational, 4-bit nibble in → 8-bit ASCII out, uppercase letters. One instance is used, muxed by the SEND index.

## Test plan
- Send `cmd\r`, `tx_ready`=1 → bytes 72 65 73 70 0D on consecutive cycles; `command_valid`=1; first byte 2 cycles after CR.
- Write adc_channel=2 with 0x00ABCDEF, then send `voltagech3\r` → `00ABCDEF\r`; `command_valid`=5. Repeat with `tx_ready` toggling 1/0 → same bytes, each held while stalled.
- Send `voltagech9\r` and `voltagech03\r` with NUM_CH=8 → `?\r` and `command_valid`=8'hFF if `CMD_ERROR_RESP_EN` is defined; otherwise no `tx_valid`.
- Send 20 chars then `\r` → overflow; error handling as above. Then send `cmd\r` → correct `resp\r`.
- Send `reset\r` → `rs_232_reset` high for exactly 1 cycle; no tx. Assert `reset` midway through a voltage response → `tx_valid`=0 and all channel values 0 immediately.
